// File: rtl/music_pkg.sv
// Shared constants and types for the music path: command codes issued by the
// key-command front end, the tone index range understood by the tone decoder,
// and the default system clock frequency.
package music_pkg;

  localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;

  // Highest legal tone index (top entry of the decoder table).
  localparam int unsigned TONE_MAX = 28;
  localparam int unsigned TONE_W   = 5;

  typedef logic [TONE_W-1:0] tone_t;
  typedef logic [1:0]        cmd_code_t;

  localparam cmd_code_t CMD_UP      = 2'd0;
  localparam cmd_code_t CMD_DOWN    = 2'd1;
  localparam cmd_code_t CMD_SPEED   = 2'd2;
  localparam cmd_code_t CMD_RESTART = 2'd3;

endpackage

// File: rtl/tone_stepper_if.sv
// Command/status bundle between the keyboard front end (master) and the tone
// stepper (slave).
//   cmd_valid  one-cycle command strobe
//   cmd_code   command, sampled only while cmd_valid is high
//   tone       current tone index
//   dir        1 = ascending, 0 = descending
//   fast       1 = fast beat rate active
//   beat       one-cycle pulse per beat boundary
//   at_limit   next beat cannot move the tone
interface tone_stepper_if;
  import music_pkg::*;

  logic      cmd_valid;
  cmd_code_t cmd_code;
  tone_t     tone;
  logic      dir;
  logic      fast;
  logic      beat;
  logic      at_limit;

  modport master (
    output cmd_valid,
    output cmd_code,
    input  tone,
    input  dir,
    input  fast,
    input  beat,
    input  at_limit
  );

  modport slave (
    input  cmd_valid,
    input  cmd_code,
    output tone,
    output dir,
    output fast,
    output beat,
    output at_limit
  );

endinterface

// File: rtl/beat_divider.sv
// Beat tick generator. Counts system clocks and emits a registered one-cycle
// beat pulse each time the counter wraps.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   fast   selects the FAST_HZ period instead of the SLOW_HZ period
//   clear  restarts the period from zero and suppresses a coincident beat
//   beat   one-cycle pulse on every period boundary
module beat_divider #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SLOW_HZ = 1,
  parameter int unsigned FAST_HZ = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fast,
  input  logic clear,
  output logic beat
);

  localparam int unsigned SlowPeriod = CLK_HZ / SLOW_HZ;
  localparam int unsigned FastPeriod = CLK_HZ / FAST_HZ;
  // The slow period is the longest one, so it sizes the counter.
  localparam int unsigned CntW = (SlowPeriod > 1) ? $clog2(SlowPeriod) : 1;

  localparam logic [CntW-1:0] SlowLast = CntW'(SlowPeriod - 1);
  localparam logic [CntW-1:0] FastLast = CntW'(FastPeriod - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            beat_q, beat_d;
  logic            wrap;

  always_comb begin
    wrap   = (cnt_q == (fast ? FastLast : SlowLast));
    beat_d = wrap && !clear;
    if (clear || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      beat_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      beat_q <= beat_d;
    end
  end

  assign beat = beat_q;

endmodule

// File: rtl/tone_stepper.sv
// Tone-index sequencer. Steps a saturating tone index up or down once per beat
// and decodes direction, speed and restart commands from the keyboard front end.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    command strobe/code in; tone, dir, fast, beat, at_limit out
module tone_stepper #(
  parameter int unsigned CLK_HZ   = music_pkg::CLK_HZ_DEFAULT,
  parameter int unsigned SLOW_HZ  = 1,
  parameter int unsigned FAST_HZ  = 2,
  parameter int unsigned TONE_MAX = music_pkg::TONE_MAX
) (
  input  logic           clk,
  input  logic           rst_n,
  tone_stepper_if.slave  bus
);

  localparam int unsigned ToneW = music_pkg::TONE_W;
  localparam logic [ToneW-1:0] ToneTop = ToneW'(TONE_MAX);

  typedef enum logic [0:0] {
    StDescend = 1'b0,
    StAscend  = 1'b1
  } dir_state_e;

  dir_state_e       state_q, state_d;
  logic [ToneW-1:0] tone_q, tone_d;
  logic             fast_q, fast_d;
  logic             beat;
  logic             cmd_up, cmd_down, cmd_speed, cmd_restart;

  always_comb begin
    cmd_up      = 1'b0;
    cmd_down    = 1'b0;
    cmd_speed   = 1'b0;
    cmd_restart = 1'b0;
    if (bus.cmd_valid) begin
      unique case (bus.cmd_code)
        music_pkg::CMD_UP:      cmd_up      = 1'b1;
        music_pkg::CMD_DOWN:    cmd_down    = 1'b1;
        music_pkg::CMD_SPEED:   cmd_speed   = 1'b1;
        music_pkg::CMD_RESTART: cmd_restart = 1'b1;
      endcase
    end
  end

  beat_divider #(
    .CLK_HZ  (CLK_HZ),
    .SLOW_HZ (SLOW_HZ),
    .FAST_HZ (FAST_HZ)
  ) u_beat_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .fast  (fast_q),
    .clear (cmd_speed | cmd_restart),
    .beat  (beat)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAscend:  if (cmd_down) state_d = StDescend;
      StDescend: if (cmd_up)   state_d = StAscend;
      default:   state_d = StAscend;
    endcase
    if (cmd_restart) state_d = StAscend;

    fast_d = cmd_speed ? ~fast_q : fast_q;
    if (cmd_restart) fast_d = 1'b0;

    // The step follows the direction being written this cycle, so a direction
    // command coincident with a beat steps the new way.
    tone_d = tone_q;
    if (cmd_restart) begin
      tone_d = '0;
    end else if (beat) begin
      if (state_d == StAscend) begin
        if (tone_q < ToneTop) tone_d = tone_q + ToneW'(1);
      end else begin
        if (tone_q != '0) tone_d = tone_q - ToneW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAscend;
      tone_q  <= '0;
      fast_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tone_q  <= tone_d;
      fast_q  <= fast_d;
    end
  end

  assign bus.tone     = tone_q;
  assign bus.dir      = (state_q == StAscend);
  assign bus.fast     = fast_q;
  assign bus.beat     = beat;
  assign bus.at_limit = (state_q == StAscend) ? (tone_q == ToneTop) : (tone_q == '0);

endmodule

// File: tb/tb_tone_stepper.sv
module tb_tone_stepper;
  import music_pkg::*;

  typedef struct {
    int          cyc;
    logic [4:0]  tone;
    logic        dir;
    logic        fast;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   base = 0;
  exp_t exp_q[$];
  exp_t cur;
  logic chk_pending = 1'b0;

  tone_stepper_if bus ();

  tone_stepper #(
    .CLK_HZ   (20),
    .SLOW_HZ  (1),
    .FAST_HZ  (2),
    .TONE_MAX (28)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard: each observed beat pops the next expected beat; the cycle
  // after it, the stepped tone/dir/fast are compared.
  always @(negedge clk) begin
    cyc++;
    if (chk_pending) begin
      chk_pending = 1'b0;
      total++;
      if (bus.tone !== cur.tone || bus.dir !== cur.dir || bus.fast !== cur.fast) begin
        bad++;
        $display("FAIL step_after_beat@%0d: tone=%0d dir=%b fast=%b want tone=%0d dir=%b fast=%b",
                 cur.cyc - base, bus.tone, bus.dir, bus.fast, cur.tone, cur.dir, cur.fast);
      end
    end
    if (bus.beat === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat: beat at rel cycle %0d want none", cyc - base);
      end else begin
        cur = exp_q.pop_front();
        if (cyc != cur.cyc) begin
          bad++;
          $display("FAIL beat_time: beat at rel cycle %0d want %0d", cyc - base, cur.cyc - base);
        end
        chk_pending = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic goto(input int n);
    while (cyc + 1 < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input cmd_code_t code);
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = code;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = CMD_RESTART;  // must be ignored while cmd_valid is low
  endtask

  task automatic push_beat(input int c, input int t, input logic d, input logic f);
    exp_q.push_back('{cyc: c, tone: 5'(t), dir: d, fast: f});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = cyc + 1;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = CMD_RESTART;
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.tone !== 5'd0 || bus.dir !== 1'b1 || bus.fast !== 1'b0 || bus.beat !== 1'b0 ||
        bus.at_limit !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: tone=%0d dir=%b fast=%b beat=%b at_limit=%b want 0 1 0 0 0",
               bus.tone, bus.dir, bus.fast, bus.beat, bus.at_limit);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = cyc + 1;
  endtask

  task automatic test_ascend();
    for (int k = 1; k <= 29; k++) push_beat(base + 20 * k, (k > 28) ? 28 : k, 1'b1, 1'b0);
    goto(base + 542);
    total++;
    if (bus.tone !== 5'd27 || bus.at_limit !== 1'b0) begin
      bad++;
      $display("FAIL below_top: tone=%0d at_limit=%b want 27 0", bus.tone, bus.at_limit);
    end
    goto(base + 562);
    total++;
    if (bus.tone !== 5'd28 || bus.at_limit !== 1'b1) begin
      bad++;
      $display("FAIL at_top: tone=%0d at_limit=%b want 28 1", bus.tone, bus.at_limit);
    end
    goto(base + 582);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL ascend_beats: %0d beats missing want 0", exp_q.size());
    end
  endtask

  task automatic test_descend();
    int t;
    for (int k = 30; k <= 58; k++) begin
      t = 57 - k;
      push_beat(base + 20 * k, (t < 0) ? 0 : t, 1'b0, 1'b0);
    end
    goto(base + 589);
    pulse(CMD_DOWN);
    total++;
    if (bus.dir !== 1'b0 || bus.tone !== 5'd28 || bus.at_limit !== 1'b0) begin
      bad++;
      $display("FAIL down_cmd: dir=%b tone=%0d at_limit=%b want 0 28 0",
               bus.dir, bus.tone, bus.at_limit);
    end
    goto(base + 1162);
    total++;
    if (bus.tone !== 5'd0 || bus.at_limit !== 1'b1 || bus.dir !== 1'b0) begin
      bad++;
      $display("FAIL at_bottom: tone=%0d at_limit=%b dir=%b want 0 1 0",
               bus.tone, bus.at_limit, bus.dir);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL descend_beats: %0d beats missing want 0", exp_q.size());
    end
  endtask

  task automatic test_speed();
    do_reset();
    for (int j = 1; j <= 3; j++) push_beat(base + 15 + 10 * j, j, 1'b1, 1'b1);
    goto(base + 14);
    pulse(CMD_SPEED);
    total++;
    if (bus.fast !== 1'b1) begin
      bad++;
      $display("FAIL speed_toggle: fast=%b want 1", bus.fast);
    end
    goto(base + 47);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL speed_beats: %0d beats missing want 0", exp_q.size());
    end
  endtask

  task automatic test_dir_coincident();
    do_reset();
    for (int k = 1; k <= 5; k++) push_beat(base + 20 * k, k, 1'b1, 1'b0);
    push_beat(base + 120, 4, 1'b0, 1'b0);
    push_beat(base + 140, 3, 1'b0, 1'b0);
    goto(base + 49);
    pulse(CMD_UP);  // repeat of current direction: no effect
    goto(base + 120);
    total++;
    if (bus.beat !== 1'b1 || bus.tone !== 5'd5 || bus.dir !== 1'b1) begin
      bad++;
      $display("FAIL pre_coincident: beat=%b tone=%0d dir=%b want 1 5 1",
               bus.beat, bus.tone, bus.dir);
    end
    pulse(CMD_DOWN);
    goto(base + 142);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL coincident_beats: %0d beats missing want 0", exp_q.size());
    end
  endtask

  task automatic test_restart();
    do_reset();
    for (int j = 1; j <= 13; j++) push_beat(base + 1 + 10 * j, j, 1'b1, 1'b1);
    push_beat(base + 141, 12, 1'b0, 1'b1);
    push_beat(base + 171, 1, 1'b1, 1'b0);
    pulse(CMD_SPEED);
    goto(base + 134);
    pulse(CMD_DOWN);
    goto(base + 150);
    total++;
    if (bus.tone !== 5'd12 || bus.dir !== 1'b0 || bus.fast !== 1'b1) begin
      bad++;
      $display("FAIL pre_restart: tone=%0d dir=%b fast=%b want 12 0 1",
               bus.tone, bus.dir, bus.fast);
    end
    pulse(CMD_RESTART);
    total++;
    if (bus.beat !== 1'b0 || bus.tone !== 5'd0 || bus.dir !== 1'b1 || bus.fast !== 1'b0) begin
      bad++;
      $display("FAIL restart: beat=%b tone=%0d dir=%b fast=%b want 0 0 1 0",
               bus.beat, bus.tone, bus.dir, bus.fast);
    end
    goto(base + 173);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL restart_beats: %0d beats missing want 0", exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 1; k <= 7; k++) push_beat(base + 20 * k, k, 1'b1, 1'b0);
    goto(base + 144);
    pulse(CMD_DOWN);
    goto(base + 153);
    total++;
    if (bus.tone !== 5'd7 || bus.dir !== 1'b0) begin
      bad++;
      $display("FAIL pre_async: tone=%0d dir=%b want 7 0", bus.tone, bus.dir);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.tone !== 5'd0 || bus.dir !== 1'b1 || bus.fast !== 1'b0 || bus.beat !== 1'b0 ||
        bus.at_limit !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: tone=%0d dir=%b fast=%b beat=%b at_limit=%b want 0 1 0 0 0",
               bus.tone, bus.dir, bus.fast, bus.beat, bus.at_limit);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = cyc + 1;
    push_beat(base + 20, 1, 1'b1, 1'b0);
    goto(base + 22);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL post_reset_beat: %0d beats missing want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_ascend();
    test_descend();
    test_speed();
    test_dir_coincident();
    test_restart();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
